// File: rtl/mac_ctrl_pkg.sv
// Shared types and default constants for the MAC job sequencer and the mac_unit it drives.
package mac_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      STREAM,
      DRAIN,
      DONE
   } mac_seq_state_e;

   localparam int DEFAULT_DATA_W       = 8;
   localparam int DEFAULT_ACC_W        = 20;
   localparam int DEFAULT_LEN_W        = 10;
   // Must match the pipeline depth of mac_unit from last enabled edge to a settled accumulator.
   localparam int DEFAULT_DRAIN_CYCLES = 2;

   localparam longint ACC_MAX = (longint'(1) <<< (DEFAULT_ACC_W - 1)) - 1;
   localparam longint ACC_MIN = -(longint'(1) <<< (DEFAULT_ACC_W - 1));

endpackage

// File: rtl/mac_seq_ctrl.sv
// Single-job sequencer for one mac_unit: accept command, clear, stream K operand pairs,
// wait out the MAC latency, then hold the captured result until it is accepted.
module mac_seq_ctrl
   import mac_ctrl_pkg::*;
#(
   parameter int DATA_W       = DEFAULT_DATA_W,
   parameter int ACC_W        = DEFAULT_ACC_W,
   parameter int LEN_W        = DEFAULT_LEN_W,
   parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              cmd_int4,
   input  logic              abort,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [DATA_W-1:0] op_weight,
   input  logic [DATA_W-1:0] op_input,
   output logic              mac_enable,
   output logic              mac_clear_acc,
   output logic              mac_int4_mode,
   output logic [DATA_W-1:0] mac_weight,
   output logic [DATA_W-1:0] mac_input,
   input  logic [ACC_W-1:0]  mac_accumulator,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ACC_W-1:0]  res_data,
   output logic              res_sat,
   output logic              busy
);

   localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
   localparam logic [ACC_W-1:0] ACC_MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

   mac_seq_state_e     state_q, state_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   beat_q, beat_d;
   logic [DRAIN_W-1:0] drain_q, drain_d;
   logic               int4_q, int4_d;
   logic [ACC_W-1:0]   res_data_q, res_data_d;
   logic               res_sat_q, res_sat_d;

   // Abort wins over the stream handshake so an aborting cycle never consumes a beat.
   assign cmd_ready     = (state_q == IDLE);
   assign busy          = (state_q != IDLE);
   assign op_ready      = (state_q == STREAM) && !abort;
   assign mac_enable    = op_valid && op_ready;
   assign mac_clear_acc = (state_q == CLEAR) && !abort;
   assign mac_int4_mode = (state_q != IDLE) && int4_q;
   assign mac_weight    = (state_q == STREAM) ? op_weight : '0;
   assign mac_input     = (state_q == STREAM) ? op_input  : '0;
   assign res_valid     = (state_q == DONE);
   assign res_data      = res_data_q;
   assign res_sat       = res_sat_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         len_q      <= '0;
         beat_q     <= '0;
         drain_q    <= '0;
         int4_q     <= 1'b0;
         res_data_q <= '0;
         res_sat_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         beat_q     <= beat_d;
         drain_q    <= drain_d;
         int4_q     <= int4_d;
         res_data_q <= res_data_d;
         res_sat_q  <= res_sat_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      beat_d     = beat_q;
      drain_d    = drain_q;
      int4_d     = int4_q;
      res_data_d = res_data_q;
      res_sat_d  = res_sat_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               len_d   = cmd_len;
               int4_d  = cmd_int4;
               beat_d  = '0;
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               drain_d = '0;
               state_d = (len_q != '0) ? STREAM : DRAIN;
            end
         end
         STREAM: begin
            if (abort) begin
               state_d = IDLE;
            end else if (mac_enable) begin
               beat_d = beat_q + LEN_W'(1);
               if (beat_d == len_q) begin
                  drain_d = '0;
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (abort) begin
               state_d = IDLE;
            end else if (drain_q == DRAIN_LAST) begin
               // An empty job reports zero regardless of what the accumulator shows.
               res_data_d = (len_q == '0) ? '0 : mac_accumulator;
               res_sat_d  = (len_q != '0) &&
                            ((mac_accumulator == ACC_MAX_V) || (mac_accumulator == ACC_MIN_V));
               state_d    = DONE;
            end else begin
               drain_d = drain_q + DRAIN_W'(1);
            end
         end
         DONE: begin
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
